// File: rtl/branch_resolve_bp_if.sv
// Signal bundle between the pipeline (master) and the branch resolution unit (slave).
interface branch_resolve_bp_if #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic [PC_W-1:0]  fetch_pc;
    logic             fetch_pred_taken;
    logic             ex_valid;
    logic             ex_flush;
    logic [PC_W-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rs1;
    logic [XLEN-1:0]  ex_rs2;
    logic [2:0]       ex_branch_type;
    logic             ex_pred_taken;
    logic             res_valid;
    logic             res_taken;
    logic             res_mispredict;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispredicts;

    modport master (
        output fetch_pc, ex_valid, ex_flush, ex_pc, ex_rs1, ex_rs2,
               ex_branch_type, ex_pred_taken,
        input  fetch_pred_taken, res_valid, res_taken, res_mispredict,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  fetch_pc, ex_valid, ex_flush, ex_pc, ex_rs1, ex_rs2,
               ex_branch_type, ex_pred_taken,
        output fetch_pred_taken, res_valid, res_taken, res_mispredict,
               stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_resolve_bp.sv
// Branch resolution unit: evaluates branch conditions in execute, trains a bimodal
// table of 2-bit saturating counters, and serves combinational fetch predictions.
module branch_resolve_bp #(
    parameter int XLEN        = 32,
    parameter int PC_W        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 16
) (
    input logic                clk,
    input logic                rst_n,
    branch_resolve_bp_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic [2:0] {
        BR_EQ     = 3'd0,
        BR_NE     = 3'd1,
        BR_NEVER  = 3'd2,
        BR_ALWAYS = 3'd3,
        BR_LT     = 3'd4,
        BR_GE     = 3'd5,
        BR_LTU    = 3'd6,
        BR_GEU    = 3'd7
    } brType_e;

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [IDX_W-1:0] fetchIdx;
    logic [IDX_W-1:0] exIdx;
    logic [1:0]       entryCur;
    logic [1:0]       entry_d;
    logic             taken;
    logic             isCond;
    logic             resolve;
    logic             resValid_q, resValid_d;
    logic             resTaken_q, resTaken_d;
    logic             resMispredict_q, resMispredict_d;
    logic [CNT_W-1:0] statBranches_q, statBranches_d;
    logic [CNT_W-1:0] statMispredicts_q, statMispredicts_d;
    logic             unusedPcBits;

    assign fetchIdx = bus.fetch_pc[IDX_W+1:2];
    assign exIdx    = bus.ex_pc[IDX_W+1:2];
    assign entryCur = bht_q[exIdx];
    assign resolve  = bus.ex_valid && !bus.ex_flush;

    // Fetch sees the table as it stood before this cycle's update; no bypass.
    assign bus.fetch_pred_taken = bht_q[fetchIdx][1];

    assign unusedPcBits = ^{bus.fetch_pc[PC_W-1:IDX_W+2], bus.fetch_pc[1:0],
                            bus.ex_pc[PC_W-1:IDX_W+2], bus.ex_pc[1:0]};

    always_comb begin
        taken  = 1'b0;
        isCond = 1'b1;
        case (brType_e'(bus.ex_branch_type))
            BR_EQ:     taken = (bus.ex_rs1 == bus.ex_rs2);
            BR_NE:     taken = (bus.ex_rs1 != bus.ex_rs2);
            BR_NEVER:  begin taken = 1'b0; isCond = 1'b0; end
            BR_ALWAYS: begin taken = 1'b1; isCond = 1'b0; end
            BR_LT:     taken = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
            BR_GE:     taken = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
            BR_LTU:    taken = (bus.ex_rs1 <  bus.ex_rs2);
            BR_GEU:    taken = (bus.ex_rs1 >= bus.ex_rs2);
            default:   taken = 1'b0;
        endcase
    end

    // Only conditional branches train the table and the statistics.
    always_comb begin
        resValid_d        = resolve;
        resTaken_d        = resolve && taken;
        resMispredict_d   = resolve && (taken != bus.ex_pred_taken);
        statBranches_d    = statBranches_q;
        statMispredicts_d = statMispredicts_q;
        entry_d           = entryCur;
        if (resolve && isCond) begin
            if (statBranches_q != '1) begin
                statBranches_d = statBranches_q + CNT_W'(1);
            end
            if ((taken != bus.ex_pred_taken) && (statMispredicts_q != '1)) begin
                statMispredicts_d = statMispredicts_q + CNT_W'(1);
            end
            if (taken) begin
                if (entryCur != 2'b11) entry_d = entryCur + 2'd1;
            end else begin
                if (entryCur != 2'b00) entry_d = entryCur - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
            resValid_q        <= 1'b0;
            resTaken_q        <= 1'b0;
            resMispredict_q   <= 1'b0;
            statBranches_q    <= '0;
            statMispredicts_q <= '0;
        end else begin
            if (resolve && isCond) begin
                bht_q[exIdx] <= entry_d;
            end
            resValid_q        <= resValid_d;
            resTaken_q        <= resTaken_d;
            resMispredict_q   <= resMispredict_d;
            statBranches_q    <= statBranches_d;
            statMispredicts_q <= statMispredicts_d;
        end
    end

    assign bus.res_valid        = resValid_q;
    assign bus.res_taken        = resTaken_q;
    assign bus.res_mispredict   = resMispredict_q;
    assign bus.stat_branches    = statBranches_q;
    assign bus.stat_mispredicts = statMispredicts_q;
endmodule

// File: tb/tb_branch_resolve_bp.sv
// Bench for branch_resolve_bp: directed scenarios plus random traffic checked
// against an array-based predictor model with small statistics counters.
module tb_branch_resolve_bp;
    localparam int XLEN    = 32;
    localparam int PC_W    = 32;
    localparam int ENTRIES = 64;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int bhtM [ENTRIES];
    int brM;
    int misM;

    branch_resolve_bp_if #(.XLEN(XLEN), .PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    branch_resolve_bp #(
        .XLEN(XLEN), .PC_W(PC_W), .BHT_ENTRIES(ENTRIES), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic int idxOf(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    // Condition codes evaluated on integers wide enough to hold both interpretations.
    function automatic bit refTaken(input int t, input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sa, sb;
        ua = a;
        ub = b;
        sa = (ua >= 64'd2147483648) ? ua - 64'd4294967296 : ua;
        sb = (ub >= 64'd2147483648) ? ub - 64'd4294967296 : ub;
        case (t)
            0: return ua == ub;
            1: return ua != ub;
            2: return 1'b0;
            3: return 1'b1;
            4: return sa < sb;
            5: return sa >= sb;
            6: return ua < ub;
            7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void resetModel();
        for (int i = 0; i < ENTRIES; i++) bhtM[i] = 1;
        brM  = 0;
        misM = 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check the fetch prediction, then check results after the edge.
    task automatic applyStimulus(input string tag, input bit valid, input bit flush,
                                 input logic [31:0] pc, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input int t, input bit pred,
                                 input logic [31:0] fpc);
        bit tk, res, cond, expV, expT, expM;
        int ix;
        @(negedge clk);
        bus.ex_valid       = valid;
        bus.ex_flush       = flush;
        bus.ex_pc          = pc;
        bus.ex_rs1         = rs1;
        bus.ex_rs2         = rs2;
        bus.ex_branch_type = 3'(t);
        bus.ex_pred_taken  = pred;
        bus.fetch_pc       = fpc;
        #1;
        checkOutput({tag, "/pred"}, 32'(bus.fetch_pred_taken), 32'(bhtM[idxOf(fpc)] >= 2));
        res  = valid && !flush;
        tk   = refTaken(t, rs1, rs2);
        cond = (t != 2) && (t != 3);
        expV = res;
        expT = res && tk;
        expM = res && (tk != pred);
        if (res && cond) begin
            ix = idxOf(pc);
            bhtM[ix] = tk ? ((bhtM[ix] < 3) ? bhtM[ix] + 1 : 3) : ((bhtM[ix] > 0) ? bhtM[ix] - 1 : 0);
            if (brM < CNT_MAX) brM++;
            if ((tk != pred) && (misM < CNT_MAX)) misM++;
        end
        @(posedge clk);
        #1;
        checkOutput({tag, "/res_valid"}, 32'(bus.res_valid), 32'(expV));
        checkOutput({tag, "/res_taken"}, 32'(bus.res_taken), 32'(expT));
        checkOutput({tag, "/res_mispredict"}, 32'(bus.res_mispredict), 32'(expM));
        checkOutput({tag, "/stat_branches"}, 32'(bus.stat_branches), 32'(brM));
        checkOutput({tag, "/stat_mispredicts"}, 32'(bus.stat_mispredicts), 32'(misM));
    endtask

    task automatic checkPred(input string tag, input logic [31:0] fpc, input bit exp);
        bus.fetch_pc = fpc;
        #1;
        checkOutput(tag, 32'(bus.fetch_pred_taken), 32'(exp));
    endtask

    // Reset lands mid-cycle while the previous step's inputs are still driven.
    task automatic doReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst/res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("rst/res_taken", 32'(bus.res_taken), 32'd0);
        checkOutput("rst/res_mispredict", 32'(bus.res_mispredict), 32'd0);
        checkOutput("rst/stat_branches", 32'(bus.stat_branches), 32'd0);
        checkOutput("rst/stat_mispredicts", 32'(bus.stat_mispredicts), 32'd0);
        checkOutput("rst/pred", 32'(bus.fetch_pred_taken), 32'd0);
        bus.ex_valid = 1'b0;
        bus.ex_flush = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        resetModel();
    endtask

    initial begin
        logic [31:0] pc, fpc, rs1, rs2;
        bus.fetch_pc       = '0;
        bus.ex_valid       = 1'b0;
        bus.ex_flush       = 1'b0;
        bus.ex_pc          = '0;
        bus.ex_rs1         = '0;
        bus.ex_rs2         = '0;
        bus.ex_branch_type = '0;
        bus.ex_pred_taken  = 1'b0;
        resetModel();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("init/res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("init/stat_branches", 32'(bus.stat_branches), 32'd0);

        $display("[TB] signed/unsigned compare");
        applyStimulus("lt", 1, 0, 32'h20, 32'hFFFF_FFFF, 32'h1, 4, 0, 32'h20);
        checkOutput("lt/const", 32'(bus.res_taken), 32'd1);
        applyStimulus("ltu", 1, 0, 32'h20, 32'hFFFF_FFFF, 32'h1, 6, 0, 32'h20);
        checkOutput("ltu/const", 32'(bus.res_taken), 32'd0);
        applyStimulus("ge", 1, 0, 32'h20, 32'hFFFF_FFFF, 32'h1, 5, 0, 32'h20);
        checkOutput("ge/const", 32'(bus.res_taken), 32'd0);
        applyStimulus("geu", 1, 0, 32'h20, 32'hFFFF_FFFF, 32'h1, 7, 0, 32'h20);
        checkOutput("geu/const", 32'(bus.res_taken), 32'd1);
        applyStimulus("eq_equal", 1, 0, 32'h24, 32'h1234, 32'h1234, 0, 1, 32'h24);
        checkOutput("eq_equal/const", 32'(bus.res_taken), 32'd1);
        applyStimulus("eq_diff", 1, 0, 32'h24, 32'h1234, 32'h1235, 0, 1, 32'h24);
        checkOutput("eq_diff/const", 32'(bus.res_taken), 32'd0);
        applyStimulus("ne_equal", 1, 0, 32'h28, 32'h55, 32'h55, 1, 0, 32'h28);
        checkOutput("ne_equal/const", 32'(bus.res_taken), 32'd0);
        applyStimulus("ne_diff", 1, 0, 32'h28, 32'h55, 32'h56, 1, 0, 32'h28);
        checkOutput("ne_diff/const", 32'(bus.res_taken), 32'd1);

        $display("[TB] counter training");
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus("train_t", 1, 0, 32'h100, 32'h7, 32'h7, 0, 1, 32'h100);
            checkPred("train_t/after", 32'h100, 1'b1);
        end
        applyStimulus("train_nt1", 1, 0, 32'h100, 32'h7, 32'h8, 0, 1, 32'h100);
        checkPred("train_nt1/after", 32'h100, 1'b1);
        applyStimulus("train_nt2", 1, 0, 32'h100, 32'h7, 32'h8, 0, 1, 32'h100);
        checkPred("train_nt2/after", 32'h100, 1'b0);
        applyStimulus("train_t5", 1, 0, 32'h100, 32'h7, 32'h7, 0, 0, 32'h100);
        checkPred("train_t5/after", 32'h100, 1'b1);

        $display("[TB] mid-stream reset and prediction sweep");
        doReset();
        for (int i = 0; i < ENTRIES; i++) begin
            checkPred("sweep", 32'(i * 4), 1'b0);
        end

        $display("[TB] mispredict and stats");
        doReset();
        applyStimulus("bne_misp", 1, 0, 32'h104, 32'h1, 32'h2, 1, 0, 32'h104);
        checkOutput("bne_misp/const", 32'(bus.res_mispredict), 32'd1);
        applyStimulus("jmp_misp", 1, 0, 32'h108, 32'h1, 32'h2, 3, 0, 32'h108);
        checkOutput("jmp_misp/const", 32'(bus.res_mispredict), 32'd1);
        checkOutput("jmp/stat_branches", 32'(bus.stat_branches), 32'd1);
        checkOutput("jmp/stat_mispredicts", 32'(bus.stat_mispredicts), 32'd1);
        checkPred("jmp/table", 32'h108, 1'b0);

        $display("[TB] collision and flush");
        doReset();
        applyStimulus("collide", 1, 0, 32'h10C, 32'h9, 32'h9, 0, 0, 32'h10C);
        checkPred("collide/next", 32'h10C, 1'b1);
        doReset();
        applyStimulus("flush", 1, 1, 32'h10C, 32'h9, 32'h9, 0, 0, 32'h10C);
        checkOutput("flush/res_valid", 32'(bus.res_valid), 32'd0);
        checkPred("flush/next", 32'h10C, 1'b0);

        $display("[TB] statistics saturation");
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus("sat", 1, 0, 32'($urandom_range(0, 63) * 4), 32'h3, 32'h3, 0, 0, 32'h0);
        end
        checkOutput("sat/stat_branches", 32'(bus.stat_branches), 32'd15);
        checkOutput("sat/stat_mispredicts", 32'(bus.stat_mispredicts), 32'd15);

        $display("[TB] random traffic");
        doReset();
        for (int i = 0; i < 150; i++) begin
            pc  = 32'($urandom_range(0, 15) * 4);
            fpc = ($urandom_range(0, 2) == 0) ? pc : 32'($urandom_range(0, 15) * 4);
            rs2 = $urandom();
            case ($urandom_range(0, 3))
                0:       rs1 = rs2;
                1:       rs1 = 32'($urandom_range(0, 4));
                default: rs1 = $urandom();
            endcase
            applyStimulus("rand", $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 1,
                          pc, rs1, rs2, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), fpc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_resolve_bp.md
# branch_resolve_bp

Parametrised branch resolution unit with a bimodal branch predictor for the pipelined core. Fetch reads a taken/not-taken prediction from a table of 2-bit saturating counters indexed by PC. Execute evaluates the branch condition on the two register operands, trains the table, and reports the registered outcome and misprediction one cycle later. Saturating branch and mispredict counters support performance measurement. The block replaces the single-cycle branch comparator in the pipelined datapath.

## Interface

Reset and clocking (already decided): one clock, `clk`. Reset `rst_n` is asynchronous and active-low.

Parameters:
- `XLEN`, 32: operand width.
- `PC_W`, 32: PC width.
- `BHT_ENTRIES`, 64: predictor entries. Must be a power of two, ≥ 2. `IDX_W = $clog2(BHT_ENTRIES)`.
- `CNT_W`, 16: width of each statistics counter.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: async active-low reset.
- `fetch_pc` in PC_W: PC of the instruction being fetched.
- `fetch_pred_taken` out 1: prediction for `fetch_pc`. Combinational table read.
- `ex_valid` in 1: a branch/jump is in execute this cycle.
- `ex_flush` in 1: kill the execute instruction. Wins over `ex_valid`.
- `ex_pc` in PC_W: PC of the execute instruction.
- `ex_rs1` in XLEN: first operand.
- `ex_rs2` in XLEN: second operand.
- `ex_branch_type` in 3: condition code.
- `ex_pred_taken` in 1: prediction carried down the pipe with the instruction.
- `res_valid` out 1: registered resolution valid.
- `res_taken` out 1: registered actual outcome.
- `res_mispredict` out 1: registered `res_taken != ex_pred_taken`.
- `stat_branches` out CNT_W: count of resolved conditional branches.
- `stat_mispredicts` out CNT_W: count of mispredicted conditional branches.

## Operation

- Index: `idx = pc[IDX_W+1:2]`, used for both fetch and execute.
- Condition codes for `ex_branch_type`:
  - 0: EQ
  - 1: NE
  - 2: never (taken = 0)
  - 3: always (unconditional jump, taken = 1)
  - 4: LT, signed
  - 5: GE, signed
  - 6: LTU, unsigned
  - 7: GEU, unsigned
- Codes 4/5 compare as two's complement; 6/7 compare as unsigned.
- Prediction: `fetch_pred_taken = bht[idx(fetch_pc)][1]`.
- A resolve event (`ex_valid && !ex_flush`) does the following:
  - Computes `taken` and registers `res_valid=1`, `res_taken=taken`, `res_mispredict=(taken != ex_pred_taken)`.
  - For codes 0,1,4,5,6,7 only (conditional), updates `bht[idx(ex_pc)]`: +1 if taken (saturate at 3), −1 if not taken (saturate at 0).
  - For codes 0,1,4,5,6,7 only, increments `stat_branches`, and increments `stat_mispredicts` when mispredicted.
  - Codes 2/3 still produce res_* outputs, including mispredict, but do not touch the table or the counters.
- No resolve event: `res_valid`, `res_taken` and `res_mispredict` are all 0 next cycle.
- Counter states: 0 strongly-NT, 1 weakly-NT, 2 weakly-T, 3 strongly-T.
- Statistics counters saturate at all-ones. They never wrap.

## Timing

- `fetch_pred_taken` is combinational from `fetch_pc` and current table state, with zero latency.
- Resolution latency is 1 cycle: inputs sampled at edge N appear on res_* after edge N.
- The table write takes effect at the clock edge of the resolve event.
- Fetch/execute index collision in the same cycle: the fetch read returns the pre-update value. There is no bypass.
- `ex_flush` with `ex_valid`: no table update, no stat increment, `res_valid=0`.
- Reset (async assert, any cycle, including mid-update), all values forced immediately:
  - Every BHT entry = 2'b01.
  - `res_valid`, `res_taken`, `res_mispredict` = 0.
  - Both stat counters = 0.
  - `fetch_pred_taken` = 0.
- Reset release: normal operation from the first rising edge with `rst_n=1`.

## Test plan

- **Reset and prediction**:
  - Stimulus: assert `rst_n=0` mid-stream, release, sweep `fetch_pc` over all entries.
  - Required: `fetch_pred_taken=0` everywhere, res_* = 0, stats = 0.
- **Signed/unsigned compare**:
  - Stimulus: rs1=0xFFFFFFFF, rs2=0x00000001.
  - Required, one cycle later:
    - type 4 → `res_taken=1`.
    - type 6 → `res_taken=0`.
    - type 5 → 0.
    - type 7 → 1.
  - Also cover EQ/NE with equal and unequal operands.
- **Counter training**:
  - Stimulus: resolve BEQ taken at ex_pc=0x100 four times.
  - Required: entry goes 1→2→3→3. Fetch at 0x100 predicts 1 after the first update. Two not-taken resolves return the prediction to 0.
- **Mispredict and stats**:
  - Stimulus: BNE with `ex_pred_taken=0`, actual taken. Then type 3 with `ex_pred_taken=0`.
  - Required:
    - `res_mispredict=1` both times.
    - `stat_branches=1`, `stat_mispredicts=1`.
    - Table unchanged by type 3.
- **Collision and flush**:
  - Stimulus: fetch_pc index == ex_pc index with entry=1, taken resolve.
  - Required: prediction 0 that cycle, 1 the next.
  - Stimulus: same with `ex_flush=1`.
  - Required: entry stays 1, `res_valid=0`.
- **Saturation**:
  - Stimulus: CNT_W=4, 20 mispredicted conditional branches.
  - Required: both stat counters hold at 15.
